winst_seq: RTL and testbench
============================

Name: winst_seq

Overview:
- Parametrised successor to the array write-instruction controller.
- Accepts array instructions over a valid/ready handshake and holds one active plus one pending instruction, so consecutive vectors issue back-to-back.
- Generates per-element array read/write strobes with a programmable address stride.
- Delays the write address/enable by a parameterised write-back latency, producing the write port used by the array after its datapath pipeline.

Parameters:
- ADR_W, 8: array address width.
- VSIZE_W, 8: vector length field width; max length 2^VSIZE_W-1.
- STRIDE_W, 4: unsigned address stride field width.
- WB_LAT, 3: write-back delay in cycles from par to spaw; legal range 1..8.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- inst_valid, in, 1: instruction offered.
- inst_ready, out, 1: instruction slot free.
- inst_op, in, 2: bit0 = read enable, bit1 = write enable; 0 = NOP.
- inst_padr, in, ADR_W: base array address.
- inst_vsize, in, VSIZE_W: element count.
- inst_stride, in, STRIDE_W: address increment per element.
- par_rd, out, 1: array read strobe, one element per cycle.
- par_wr, out, 1: write-intent tag accompanying par_adr.
- par_adr, out, ADR_W: current element address.
- spaw_wr, out, 1: par_wr delayed WB_LAT cycles.
- spaw_adr, out, ADR_W: par_adr delayed WB_LAT cycles.
- busy, out, 1: active instruction present, or write-back pipe not empty.
- done, out, 1: one-cycle pulse on the cycle the last element of an instruction is on par.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - par_rd, par_wr, par_adr, spaw_wr, spaw_adr, done, busy are all 0.
  - inst_ready is 1.
  - Active and pending slots are cleared; every write-back pipe stage is cleared.
  - Reset asserted mid-vector aborts the vector immediately; no further strobes.
- Handshake:
  - Accept occurs when inst_valid & inst_ready at a rising edge.
  - inst_ready = !pending_valid. It is a registered-state function with no combinational path from inst_valid.
  - Payload is sampled only on accept.
- Slot rules:
  - An accept loads the active slot if the active slot is empty or finishing this cycle; otherwise it loads the pending slot.
  - When the active slot finishes, the pending slot moves to active in the same edge. The next instruction's first element appears on par on the cycle after the previous last element: zero bubbles.
- State machine:
  - States IDLE and ISSUE.
  - IDLE -> ISSUE on load of a non-NOP instruction with vsize != 0.
  - ISSUE stays in ISSUE while elements remain, or while a pending instruction is ready to take over.
  - ISSUE -> IDLE after the last element when no valid pending instruction is present.
- Latency: accept at edge T while IDLE puts element 0 on par from T+1.
- Element issue (ISSUE state):
  - par_rd = op[0] and par_wr = op[1], held for vsize consecutive cycles.
  - Element k has par_adr = padr + k*stride, computed modulo 2^ADR_W; wrap-around is silent.
  - stride = 0 repeats the same address.
  - Outside ISSUE: par_rd = par_wr = 0 and par_adr holds its last value.
- NOP or vsize = 0:
  - Consumes a slot for one cycle and produces no strobes.
  - done pulses for that cycle.
  - The following instruction is still promoted.
- done: high on the cycle the last element is on par. It pulses once per instruction, NOPs included.
- Write-back pipe:
  - WB_LAT-stage shift register of {par_wr, par_adr}.
  - spaw at cycle t equals par at cycle t-WB_LAT; values are exact copies.
  - busy stays high until every stage holding wr=1 has drained.
- Simultaneous events:
  - Accept on the same edge as an active finish with no pending instruction: the new instruction goes straight to active.
  - Accept when pending is full cannot occur, because ready is 0.

Optional Feature:
- Macro: WINST_SEQ_PERF_EN.
- Defined:
  - Extra output perf_elems[31:0] counts par_rd|par_wr cycles.
  - Extra output perf_stall[31:0] counts cycles with inst_valid & !inst_ready.
  - Both counters reset to 0 and saturate at all-ones.
- Undefined: neither port nor counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then op=3, padr=0x10, vsize=4, stride=1 accepted at T:
  - par_rd = par_wr = 1 for T+1..T+4.
  - par_adr = 0x10, 0x11, 0x12, 0x13; done at T+4.
  - spaw_wr with the same addresses at T+4..T+7 (WB_LAT=3).
- Two instructions offered back-to-back (vsize=2 at 0x00, vsize=3 at 0x40 stride 2):
  - par_adr = 0x00, 0x01, 0x40, 0x42, 0x44 with no gap.
  - inst_ready is 0 while pending is full.
- Wrap case: padr=0xFE, stride=3, vsize=3, op=1 -> par_adr = 0xFE, 0x01, 0x04; par_wr = 0; spaw_wr never 1.
- NOP and vsize=0 interleaved between two reads:
  - No strobes for the NOP and vsize=0 instructions; done pulses once each.
  - Following read starts on the next cycle.
- reset_n asserted mid-vector (element 2 of 5), asynchronously between edges:
  - All outputs 0 immediately; inst_ready = 1.
  - After release, a new instruction issues normally from its own padr.
- With WINST_SEQ_PERF_EN defined: 3 instructions totalling 9 elements while valid is held during a full slot -> perf_elems = 9 and perf_stall equals the counted blocked cycles.

Source files
------------

// File: rtl/winst_seq.sv
// Array write-instruction sequencer: active + pending instruction slots, strided
// element strobes and a WB_LAT-deep write-back pipe. Optional counters: WINST_SEQ_PERF_EN.
module winst_seq #(
   parameter int ADR_W    = 8,
   parameter int VSIZE_W  = 8,
   parameter int STRIDE_W = 4,
   parameter int WB_LAT   = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                inst_valid,
   output logic                inst_ready,
   input  logic [1:0]          inst_op,
   input  logic [ADR_W-1:0]    inst_padr,
   input  logic [VSIZE_W-1:0]  inst_vsize,
   input  logic [STRIDE_W-1:0] inst_stride,
   output logic                par_rd,
   output logic                par_wr,
   output logic [ADR_W-1:0]    par_adr,
   output logic                spaw_wr,
   output logic [ADR_W-1:0]    spaw_adr,
   output logic                busy,
   output logic                done
`ifdef WINST_SEQ_PERF_EN
  ,output logic [31:0]         perf_elems,
   output logic [31:0]         perf_stall
`endif
);

   typedef struct packed {
      logic [1:0]          op;
      logic [ADR_W-1:0]    padr;
      logic [VSIZE_W-1:0]  vsize;
      logic [STRIDE_W-1:0] stride;
   } inst_t;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state, state_nx;
   logic                act_valid;
   logic [1:0]          act_op;
   logic [ADR_W-1:0]    act_adr;
   logic [VSIZE_W-1:0]  act_cnt;
   logic [STRIDE_W-1:0] act_stride;
   logic                pend_valid;
   inst_t               pend;

   inst_t in_pkt, src;
   logic  accept, act_fin, load_act, load_pend, pend_take, src_real;

   assign in_pkt     = '{op: inst_op, padr: inst_padr, vsize: inst_vsize, stride: inst_stride};
   assign inst_ready = !pend_valid;
   assign accept     = inst_valid & inst_ready;
   // NOP / zero-length instructions sit in the active slot (state IDLE) for exactly one cycle
   assign act_fin    = act_valid & ((state == IDLE) | (act_cnt == VSIZE_W'(1)));

   always_comb begin
      load_act  = 1'b0;
      load_pend = 1'b0;
      pend_take = 1'b0;
      src       = in_pkt;
      if (act_fin || !act_valid) begin
         if (pend_valid) begin
            load_act  = 1'b1;
            pend_take = 1'b1;
            src       = pend;
         end else if (accept) begin
            load_act  = 1'b1;
         end
      end else if (accept) begin
         load_pend = 1'b1;
      end
      src_real = (src.op != 2'b00) && (src.vsize != '0);
      state_nx = state;
      if (load_act)     state_nx = src_real ? ISSUE : IDLE;
      else if (act_fin) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         act_valid  <= 1'b0;
         act_op     <= '0;
         act_adr    <= '0;
         act_cnt    <= '0;
         act_stride <= '0;
         pend_valid <= 1'b0;
         pend       <= '0;
      end else begin
         state     <= state_nx;
         act_valid <= load_act | (act_valid & !act_fin);
         if (load_act) begin
            act_op     <= src.op;
            act_cnt    <= src.vsize;
            act_stride <= src.stride;
            // par_adr keeps its last value across non-strobing instructions
            if (src_real) act_adr <= src.padr;
         end else if (state == ISSUE && !act_fin) begin
            act_adr <= act_adr + ADR_W'(act_stride);
            act_cnt <= act_cnt - VSIZE_W'(1);
         end
         if (load_pend) begin
            pend_valid <= 1'b1;
            pend       <= in_pkt;
         end else if (pend_take) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign par_rd  = (state == ISSUE) & act_op[0];
   assign par_wr  = (state == ISSUE) & act_op[1];
   assign par_adr = act_adr;
   assign done    = act_fin;

   logic [WB_LAT-1:0]            vld_pipe;
   logic [WB_LAT-1:0][ADR_W-1:0] adr_pipe;
   logic [WB_LAT:0]              vld_cat;
   logic [WB_LAT:0][ADR_W-1:0]   adr_cat;

   assign vld_cat = {vld_pipe, par_wr};
   assign adr_cat = {adr_pipe, par_adr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         adr_pipe <= '0;
      end else begin
         vld_pipe <= vld_cat[WB_LAT-1:0];
         adr_pipe <= adr_cat[WB_LAT-1:0];
      end
   end

   assign spaw_wr  = vld_pipe[WB_LAT-1];
   assign spaw_adr = adr_pipe[WB_LAT-1];
   assign busy     = act_valid | (|vld_pipe);

`ifdef WINST_SEQ_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_elems <= '0;
         perf_stall <= '0;
      end else begin
         if ((par_rd | par_wr) && perf_elems != '1)         perf_elems <= perf_elems + 32'd1;
         if (inst_valid && !inst_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_winst_seq.sv
// Directed bench for winst_seq: single vector, back-to-back issue, wrap, NOP/zero-length,
// async reset mid-vector and (with WINST_SEQ_PERF_EN) the performance counters.
module tb_winst_seq;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       inst_valid = 1'b0;
   logic       inst_ready;
   logic [1:0] inst_op = '0;
   logic [7:0] inst_padr = '0;
   logic [7:0] inst_vsize = '0;
   logic [3:0] inst_stride = '0;
   logic       par_rd, par_wr, spaw_wr, busy, done;
   logic [7:0] par_adr, spaw_adr;
`ifdef WINST_SEQ_PERF_EN
   logic [31:0] perf_elems, perf_stall;
`endif

   int n_chk = 0;
   int n_fail = 0;

   winst_seq #(.ADR_W(8), .VSIZE_W(8), .STRIDE_W(4), .WB_LAT(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
      .inst_padr(inst_padr), .inst_vsize(inst_vsize), .inst_stride(inst_stride),
      .par_rd(par_rd), .par_wr(par_wr), .par_adr(par_adr),
      .spaw_wr(spaw_wr), .spaw_adr(spaw_adr), .busy(busy), .done(done)
`ifdef WINST_SEQ_PERF_EN
     ,.perf_elems(perf_elems), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic offer(input logic [1:0] op, input logic [7:0] padr,
                        input logic [7:0] vsize, input logic [3:0] stride);
      inst_valid  = 1'b1;
      inst_op     = op;
      inst_padr   = padr;
      inst_vsize  = vsize;
      inst_stride = stride;
   endtask

   logic [7:0] exp2 [5] = '{8'h00, 8'h01, 8'h40, 8'h42, 8'h44};
   logic [7:0] exp3 [3] = '{8'hFE, 8'h01, 8'h04};
   logic [1:0] t4_op [4] = '{2'd1, 2'd0, 2'd1, 2'd1};
   logic [7:0] t4_pa [4] = '{8'h20, 8'h77, 8'h66, 8'h30};
   logic [7:0] t4_vs [4] = '{8'd1, 8'd5, 8'd0, 8'd2};
   logic       t4_rd [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [7:0] t4_ad [6] = '{8'h20, 8'h20, 8'h20, 8'h30, 8'h31, 8'h31};
   logic       t4_dn [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      // reset state
      #2;
      chk("rst_rd", par_rd, 0);     chk("rst_wr", par_wr, 0);
      chk("rst_adr", par_adr, 0);   chk("rst_spaw_wr", spaw_wr, 0);
      chk("rst_spaw_adr", spaw_adr, 0);
      chk("rst_done", done, 0);     chk("rst_busy", busy, 0);
      chk("rst_ready", inst_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      tick;

      // single vector with write-back
      offer(2'd3, 8'h10, 8'd4, 4'd1);
      tick;
      inst_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t1_rd%0d", k), par_rd, (k < 4));
         chk($sformatf("t1_wr%0d", k), par_wr, (k < 4));
         chk($sformatf("t1_adr%0d", k), par_adr, (k < 4) ? 8'h10 + k : 8'h13);
         chk($sformatf("t1_done%0d", k), done, (k == 3));
         chk($sformatf("t1_spaw_wr%0d", k), spaw_wr, (k >= 3 && k <= 6));
         if (k >= 3 && k <= 6) chk($sformatf("t1_spaw_adr%0d", k), spaw_adr, 8'h10 + k - 3);
         chk($sformatf("t1_busy%0d", k), busy, (k <= 6));
         tick;
      end

      // back-to-back, zero bubbles
      offer(2'd1, 8'h00, 8'd2, 4'd1);
      tick;
      chk("t2_adr0", par_adr, exp2[0]);
      chk("t2_ready1", inst_ready, 1);
      offer(2'd1, 8'h40, 8'd3, 4'd2);
      tick;
      inst_valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("t2_rd%0d", k), par_rd, 1);
         chk($sformatf("t2_adr%0d", k), par_adr, exp2[k]);
         chk($sformatf("t2_done%0d", k), done, (k == 1 || k == 4));
         chk($sformatf("t2_ready%0d", k), inst_ready, (k != 1));
         tick;
      end
      chk("t2_rd_end", par_rd, 0);
      repeat (4) tick;

      // address wrap, read only
      offer(2'd1, 8'hFE, 8'd3, 4'd3);
      tick;
      inst_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k < 3) chk($sformatf("t3_adr%0d", k), par_adr, exp3[k]);
         chk($sformatf("t3_rd%0d", k), par_rd, (k < 3));
         chk($sformatf("t3_wr%0d", k), par_wr, 0);
         chk($sformatf("t3_spaw_wr%0d", k), spaw_wr, 0);
         tick;
      end

      // NOP and zero-length between two reads
      for (int c = 0; c < 7; c++) begin
         if (c >= 1) begin
            chk($sformatf("t4_rd%0d", c), par_rd, t4_rd[c-1]);
            chk($sformatf("t4_wr%0d", c), par_wr, 0);
            chk($sformatf("t4_adr%0d", c), par_adr, t4_ad[c-1]);
            chk($sformatf("t4_done%0d", c), done, t4_dn[c-1]);
         end
         if (c < 4) begin
            chk($sformatf("t4_ready%0d", c), inst_ready, 1);
            offer(t4_op[c], t4_pa[c], t4_vs[c], 4'd1);
         end else begin
            inst_valid = 1'b0;
         end
         tick;
      end
      repeat (4) tick;

      // asynchronous reset mid-vector
      offer(2'd3, 8'h50, 8'd5, 4'd1);
      tick;
      inst_valid = 1'b0;
      tick;
      tick;
      chk("t5_adr_e2", par_adr, 8'h52);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rd", par_rd, 0);      chk("t5_wr", par_wr, 0);
      chk("t5_adr", par_adr, 0);    chk("t5_spaw_wr", spaw_wr, 0);
      chk("t5_spaw_adr", spaw_adr, 0);
      chk("t5_done", done, 0);      chk("t5_busy", busy, 0);
      chk("t5_ready", inst_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      chk("t5_quiet_rd", par_rd | par_wr, 0);
      offer(2'd2, 8'h60, 8'd2, 4'd4);
      tick;
      inst_valid = 1'b0;
      chk("t5_new_wr0", par_wr, 1);
      chk("t5_new_rd0", par_rd, 0);
      chk("t5_new_adr0", par_adr, 8'h60);
      tick;
      chk("t5_new_adr1", par_adr, 8'h64);
      chk("t5_new_done", done, 1);
      tick;
      chk("t5_new_end", par_wr, 0);
      repeat (4) tick;

`ifdef WINST_SEQ_PERF_EN
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;
      offer(2'd1, 8'h00, 8'd4, 4'd1);
      tick;
      offer(2'd1, 8'h10, 8'd3, 4'd1);
      tick;
      offer(2'd1, 8'h20, 8'd2, 4'd1);
      chk("p_ready2", inst_ready, 0);
      tick;
      chk("p_ready3", inst_ready, 0);
      tick;
      chk("p_ready4", inst_ready, 0);
      tick;
      chk("p_ready5", inst_ready, 1);
      tick;
      inst_valid = 1'b0;
      repeat (12) tick;
      chk("p_elems", perf_elems, 32'd9);
      chk("p_stall", perf_stall, 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
